// File: rtl/dm_pkg.sv
// Shared types and elaboration helpers for the banked data memory.
package dm_pkg;

    // The memory is either sweeping CLEAR_VAL through the array or serving accesses.
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } memState_t;

    localparam int DATA_W_DEFAULT = 16;
    localparam int ADDR_W_DEFAULT = 16;

    // One write-enable bit per byte lane.
    function automatic int beWidth(input int dataW);
        return dataW / 8;
    endfunction

    // Number of words addressed by addrW bits.
    function automatic int depthOf(input int addrW);
        return 1 << addrW;
    endfunction

    // Byte lanes only make sense for whole bytes.
    function automatic bit dataWidthOk(input int dataW);
        return (dataW > 0) && ((dataW % 8) == 0);
    endfunction

    // Only one or two output register stages are implemented.
    function automatic bit readLatOk(input int readLat);
        return (readLat == 1) || (readLat == 2);
    endfunction

endpackage

// File: rtl/dm_sram_array.sv
// Storage array with byte-lane writes and a registered synchronous read; no reset.
module dm_sram_array
    import dm_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                  clk_i,
    input  logic                  wrEn_i,
    input  logic [ADDR_W-1:0]     wrAddr_i,
    input  logic [DATA_W-1:0]     wrData_i,
    input  logic [DATA_W/8-1:0]   wrBe_i,
    input  logic                  rdEn_i,
    input  logic [ADDR_W-1:0]     rdAddr_i,
    output logic [DATA_W-1:0]     rdData_o
);

    localparam int BE_W  = beWidth(DATA_W);
    localparam int DEPTH = depthOf(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdData_q;

    // Enabled byte lanes are written and a read captures the word into the output register.
    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            for (int k = 0; k < BE_W; k++) begin
                if (wrBe_i[k]) begin
                    mem_q[wrAddr_i][8*k +: 8] <= wrData_i[8*k +: 8];
                end
            end
        end
        if (rdEn_i) begin
            rdData_q <= mem_q[rdAddr_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/dm_banked_mem.sv
// Single-port word-addressed data RAM with a sequential clear sweep and 1- or 2-cycle reads.
module dm_banked_mem
    import dm_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEFAULT,
    parameter int                ADDR_W    = ADDR_W_DEFAULT,
    parameter int                READ_LAT  = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic                  clr_i,
    output logic                  ready_o,
    output logic                  rvalid_o,
    output logic [DATA_W-1:0]     rdata_o
);

    if (!dataWidthOk(DATA_W)) begin : gBadDataW
        $error("dm_banked_mem: DATA_W must be a positive multiple of 8");
    end
    if (!readLatOk(READ_LAT)) begin : gBadReadLat
        $error("dm_banked_mem: READ_LAT must be 1 or 2");
    end

    memState_t             state_q;
    logic [ADDR_W-1:0]     clearPtr_q;
    logic                  ready_q;

    logic                  userWr;
    logic                  userRd;
    logic                  wrEn;
    logic [ADDR_W-1:0]     wrAddr;
    logic [DATA_W-1:0]     wrData;
    logic [DATA_W/8-1:0]   wrBe;
    logic [DATA_W-1:0]     arrRdata;

    // clr wins over a same-cycle request, which is simply dropped.
    assign userWr = (state_q == IDLE) && !clr_i && req_i && we_i;
    assign userRd = (state_q == IDLE) && !clr_i && req_i && !we_i;

    // Sweep the array one word per cycle, then serve accesses until clr restarts the sweep.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= CLEAR;
            clearPtr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clearPtr_q <= clearPtr_q + ADDR_W'(1);
                    if (clearPtr_q == {ADDR_W{1'b1}}) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (clr_i) begin
                        state_q <= CLEAR;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // The single write port carries the sweep while clearing and user writes otherwise.
    always_comb begin
        wrEn   = userWr;
        wrAddr = addr_i;
        wrData = wdata_i;
        wrBe   = be_i;
        if (state_q == CLEAR) begin
            wrEn   = !rst_i;
            wrAddr = clearPtr_q;
            wrData = CLEAR_VAL;
            wrBe   = '1;
        end
    end

    dm_sram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) uArray (
        .clk_i    (clk_i),
        .wrEn_i   (wrEn),
        .wrAddr_i (wrAddr),
        .wrData_i (wrData),
        .wrBe_i   (wrBe),
        .rdEn_i   (userRd),
        .rdAddr_i (addr_i),
        .rdData_o (arrRdata)
    );

    if (READ_LAT == 1) begin : gLat1
        logic valid_q;
        logic loaded_q;

        // The array register is the only stage; loaded_q forces rdata to zero until a read lands.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid_q  <= 1'b0;
                loaded_q <= 1'b0;
            end else begin
                valid_q <= userRd;
                if (userRd) begin
                    loaded_q <= 1'b1;
                end
            end
        end

        assign rvalid_o = valid_q;
        assign rdata_o  = loaded_q ? arrRdata : '0;
    end else begin : gLat2
        logic              valid1_q;
        logic              valid2_q;
        logic [DATA_W-1:0] rdata_q;

        // An extra output stage that only loads when a read is actually in flight.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid1_q <= 1'b0;
                valid2_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                valid1_q <= userRd;
                valid2_q <= valid1_q;
                if (valid1_q) begin
                    rdata_q <= arrRdata;
                end
            end
        end

        assign rvalid_o = valid2_q;
        assign rdata_o  = rdata_q;
    end

    assign ready_o = ready_q;

endmodule
